// File: rtl/pipelined_parallel_adder.sv
// pipelined_parallel_adder: WIDTH-bit add/subtract with the carry chain
// cut into STAGES registered chunks and valid/ready flow control.
module pipelined_parallel_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int C = (STAGES > 0) ? WIDTH / STAGES : 1;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH ||
      WIDTH % STAGES != 0) begin : g_bad
    $error("pipelined_parallel_adder: bad WIDTH/STAGES");
  end

  logic             adv;
  logic             ovf_n;
  logic             ovf_q;
  logic [WIDTH-1:0] qa [STAGES];
  logic [WIDTH-1:0] qb [STAGES];
  logic [WIDTH-1:0] qs [STAGES];
  logic             qc [STAGES];
  logic             qv [STAGES];

  // one global enable: a stalled output freezes every rank
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-1:0] xa;
    logic [WIDTH-1:0] xb;
    logic [WIDTH-1:0] xs;
    logic             xc;
    logic             xv;
    logic [C:0]       r;
    logic [WIDTH-1:0] ns;

    if (k == 0) begin : g_in
      assign xa = in1;
      assign xb = sub ? ~in2 : in2;
      assign xs = '0;
      assign xc = cin;
      assign xv = in_valid;
    end else begin : g_fwd
      assign xa = qa[k-1];
      assign xb = qb[k-1];
      assign xs = qs[k-1];
      assign xc = qc[k-1];
      assign xv = qv[k-1];
    end

    assign r = {1'b0, xa[k*C +: C]}
             + {1'b0, xb[k*C +: C]}
             + (C+1)'(xc);

    always_comb begin
      ns = xs;
      ns[k*C +: C] = r[C-1:0];
    end

    // carry into the MSB column is recovered from its sum bit
    if (k == STAGES-1) begin : g_ovf
      assign ovf_n = xa[WIDTH-1] ^ xb[WIDTH-1]
                   ^ ns[WIDTH-1] ^ r[C];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        qv[k] <= 1'b0;
        qa[k] <= '0;
        qb[k] <= '0;
        qs[k] <= '0;
        qc[k] <= 1'b0;
      end else if (adv) begin
        qv[k] <= xv;
        qa[k] <= xa;
        qb[k] <= xb;
        qs[k] <= ns;
        qc[k] <= r[C];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_n;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{qa[STAGES-1], qb[STAGES-1]};

  assign out_valid = qv[STAGES-1];
  assign sum       = qs[STAGES-1];
  assign cout      = qc[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_parallel_adder.sv
// tb_pipelined_parallel_adder: directed and random checks of four
// adder configurations against an arithmetic reference model.
module tb_pipelined_parallel_adder;

  localparam int N = 4;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          tx;
    int          snap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt++;

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  logic [31:0] a_d [N];
  logic [31:0] b_d [N];
  logic        c_d [N];
  logic        s_d [N];
  logic        iv_d [N];
  logic        or_d [N];
  logic [31:0] sum_o [N];
  logic        ov_o [N];
  logic        ir_o [N];
  logic        co_o [N];
  logic        vf_o [N];

  // {ovf, cout, sum}: plain arithmetic on a w-bit word
  function automatic logic [33:0] ref_add(int w, logic [31:0] a,
                                          logic [31:0] b,
                                          logic c, logic s);
    longint m, aa, bb, t;
    logic [31:0] sm;
    logic o;
    m  = (longint'(1) << w) - 1;
    aa = longint'(a) & m;
    bb = (s ? ~longint'(b) : longint'(b)) & m;
    t  = aa + bb + longint'(c);
    sm = 32'(t & m);
    o  = (aa[w-1] == bb[w-1]) && (sm[w-1] != aa[w-1]);
    return {o, t[w], sm};
  endfunction

  task automatic chk(string nm, int inst, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0h exp=%0h",
               nm, inst, got, exp);
    end
  endtask

  for (genvar i = 0; i < N; i++) begin : g_u
    localparam int W = (i == 0) ? 8 : 32;
    localparam int S = (i == 0) ? 2 : (i == 1) ? 1 :
                       (i == 2) ? 4 : 32;
    logic [W-1:0] s;
    exp_t q[$];
    int stalls = 0;

    pipelined_parallel_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv_d[i]),
      .in_ready (ir_o[i]),
      .in1      (a_d[i][W-1:0]),
      .in2      (b_d[i][W-1:0]),
      .cin      (c_d[i]),
      .sub      (s_d[i]),
      .out_valid(ov_o[i]),
      .out_ready(or_d[i]),
      .sum      (s),
      .cout     (co_o[i]),
      .ovf      (vf_o[i])
    );
    assign sum_o[i] = 32'(s);

    always @(negedge clk) begin
      bit eov;
      bit eir;
      logic [33:0] r;
      if (rst) begin
        q.delete();
        chk("rst_valid", i, 64'(ov_o[i]), 0);
      end else begin
        eov = 1'b0;
        if (q.size() > 0)
          eov = (ecnt - q[0].tx - (stalls - q[0].snap)) >= S-1;
        chk("out_valid", i, 64'(ov_o[i]), 64'(eov));
        if (eov) begin
          chk("sum", i, 64'(sum_o[i]), 64'(q[0].sum));
          chk("cout", i, 64'(co_o[i]), 64'(q[0].cout));
          chk("ovf", i, 64'(vf_o[i]), 64'(q[0].ovf));
        end
        eir = !eov || or_d[i];
        chk("in_ready", i, 64'(ir_o[i]), 64'(eir));
        if (eov && or_d[i]) void'(q.pop_front());
        else if (eov) stalls++;
        if (iv_d[i] && eir) begin
          r = ref_add(W, a_d[i], b_d[i], c_d[i], s_d[i]);
          q.push_back('{r[31:0], r[32], r[33], ecnt + 1, stalls});
        end
      end
    end

    initial begin
      wait (done);
      chk("drained", i, 64'(q.size()), 0);
    end
  end

  task automatic send(logic [31:0] a, logic [31:0] b,
                      logic c, logic s);
    bit ok;
    ok = 1'b0;
    a_d[0] = a;
    b_d[0] = b;
    c_d[0] = c;
    s_d[0] = s;
    iv_d[0] = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (ir_o[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 0, 1);
    @(posedge clk);
    #1 iv_d[0] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      a_d[i] = '0;
      b_d[i] = '0;
      c_d[i] = 1'b0;
      s_d[i] = 1'b0;
      iv_d[i] = 1'b0;
      or_d[i] = 1'b1;
    end
    #3;
    chk("reset_out_valid", 0, 64'(ov_o[0]), 0);
    chk("reset_sum", 0, 64'(sum_o[0]), 0);
    chk("reset_cout", 0, 64'(co_o[0]), 0);
    chk("reset_ovf", 0, 64'(vf_o[0]), 0);

    chk("model_10p5", 0, 64'(ref_add(8, 10, 5, 0, 0)), 34'h0_0000_000F);
    chk("model_100p50", 0, 64'(ref_add(8, 100, 50, 1, 0)), 34'h2_0000_0097);
    chk("model_255p1", 0, 64'(ref_add(8, 255, 1, 0, 0)), 34'h1_0000_0000);
    chk("model_128p128", 0, 64'(ref_add(8, 128, 128, 1, 0)), 34'h3_0000_0001);
    chk("model_0p0", 0, 64'(ref_add(8, 0, 0, 0, 0)), 34'h0_0000_0000);
    chk("model_100m50", 0, 64'(ref_add(8, 100, 50, 1, 1)), 34'h1_0000_0032);
    chk("model_50m100", 0, 64'(ref_add(8, 50, 100, 1, 1)), 34'h0_0000_00CE);

    @(posedge clk);
    #2 rst = 1'b0;
    chk("release_in_ready", 0, 64'(ir_o[0]), 1);

    @(posedge clk);
    #1;
    send(10, 5, 0, 0);
    @(posedge clk);
    #1;
    chk("t1_out_valid", 0, 64'(ov_o[0]), 1);
    chk("t1_sum", 0, 64'(sum_o[0]), 15);

    send(100, 50, 1, 0);
    send(255, 1, 0, 0);
    send(128, 128, 1, 0);
    send(0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;

    send(100, 50, 1, 1);
    send(50, 100, 1, 1);
    repeat (4) @(posedge clk);
    #1;

    fork
      begin
        send(1, 2, 0, 0);
        send(3, 4, 1, 0);
        send(200, 100, 0, 0);
      end
      begin
        or_d[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_held_valid", 0, 64'(ov_o[0]), 1);
        chk("bp_in_ready", 0, 64'(ir_o[0]), 0);
        or_d[0] = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    send(7, 8, 0, 0);
    send(9, 9, 0, 0);
    #1 rst = 1'b1;
    #1 chk("async_rst_valid", 0, 64'(ov_o[0]), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    repeat (3000) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        iv_d[i] = $urandom_range(0, 9) < 7;
        a_d[i] = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
        b_d[i] = $urandom;
        c_d[i] = 1'($urandom);
        s_d[i] = 1'($urandom);
        or_d[i] = $urandom_range(0, 3) != 0;
      end
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      iv_d[i] = 1'b0;
      or_d[i] = 1'b1;
    end
    repeat (80) @(posedge clk);
    #1 done = 1'b1;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
